// File: rtl/stream_arb_pkg.sv
// Shared widths, payload types and lock-FSM encoding for the 4:1 stream arbiter.
package stream_arb_pkg;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SEL_W-1:0]  sel_t;
  typedef enum logic {IDLE, LOCKED} lock_state_t;

  localparam sel_t PTR_RST = 2'd3;
endpackage

// File: rtl/stream_arb_4_1_if.sv
// Four-channel input / single-channel output stream bundle for stream_arb_4_1.
// in_last/out_last exist only with STREAM_ARB_PKT_LOCK_EN.
interface stream_arb_4_1_if;
  import stream_arb_pkg::*;

  logic [N_CH-1:0] in_valid;
  logic [N_CH-1:0] in_ready;
  data_t           d0;
  data_t           d1;
  data_t           d2;
  data_t           d3;
  logic            out_valid;
  logic            out_ready;
  data_t           out_data;
  sel_t            out_sel;
`ifdef STREAM_ARB_PKT_LOCK_EN
  logic [N_CH-1:0] in_last;
  logic            out_last;
`endif

`ifdef STREAM_ARB_PKT_LOCK_EN
  modport slave (
    input  in_valid, d0, d1, d2, d3, out_ready, in_last,
    output in_ready, out_valid, out_data, out_sel, out_last
  );
  modport master (
    output in_valid, d0, d1, d2, d3, out_ready, in_last,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
`else
  modport slave (
    input  in_valid, d0, d1, d2, d3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
  modport master (
    output in_valid, d0, d1, d2, d3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
`endif
endinterface

// File: rtl/mux_4_1.sv
// Existing 4:1 data mux; purely combinational word select.
module mux_4_1
  import stream_arb_pkg::*;
(
  input  data_t d0_i,
  input  data_t d1_i,
  input  data_t d2_i,
  input  data_t d3_i,
  input  sel_t  sel_i,
  output data_t y_c
);
  always_comb begin
    y_c = d0_i;
    case (sel_i)
      2'd1:    y_c = d1_i;
      2'd2:    y_c = d2_i;
      2'd3:    y_c = d3_i;
      default: y_c = d0_i;
    endcase
  end
endmodule

// File: rtl/stream_arb_4_1.sv
// Round-robin 4:1 valid/ready arbiter with a single registered output stage.
// Define STREAM_ARB_PKT_LOCK_EN to hold the grant until a beat with in_last=1.
module stream_arb_4_1
  import stream_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  stream_arb_4_1_if.slave bus
);
  logic  out_valid_q, out_valid_d;
  data_t out_data_q, out_data_d;
  sel_t  out_sel_q, out_sel_d;
  sel_t  ptr_q, ptr_d;
  sel_t  grant_c;
  logic  any_valid_c, load_c, rdy_c, accept_c;
  data_t mux_y_c;
`ifdef STREAM_ARB_PKT_LOCK_EN
  lock_state_t state_q, state_d;
  sel_t        lock_idx_q, lock_idx_d;
  logic        out_last_q, out_last_d;
`endif

  // Rotating priority: ptr+1 highest, ptr itself lowest.
  always_comb begin
    sel_t idx;
    idx     = ptr_q;
    grant_c = ptr_q;
    for (int k = N_CH - 1; k >= 1; k--) begin
      idx = ptr_q + sel_t'(k);
      if (bus.in_valid[idx]) grant_c = idx;
    end
`ifdef STREAM_ARB_PKT_LOCK_EN
    if (state_q == LOCKED) grant_c = lock_idx_q;
`endif
  end

  assign any_valid_c = |bus.in_valid;
  assign load_c      = ~out_valid_q | bus.out_ready;

  always_comb begin
    rdy_c = load_c & ~rst & any_valid_c;
`ifdef STREAM_ARB_PKT_LOCK_EN
    // While locked the owner is offered ready even before it raises valid.
    if (state_q == LOCKED) rdy_c = load_c & ~rst;
`endif
  end

  assign accept_c     = rdy_c & bus.in_valid[grant_c];
  assign bus.in_ready = rdy_c ? (N_CH'(1) << grant_c) : '0;

  mux_4_1 u_mux (
    .d0_i  (bus.d0),
    .d1_i  (bus.d1),
    .d2_i  (bus.d2),
    .d3_i  (bus.d3),
    .sel_i (grant_c),
    .y_c   (mux_y_c)
  );

  // Next-state: stall holds everything; load either captures a beat or empties.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef STREAM_ARB_PKT_LOCK_EN
    state_d     = state_q;
    lock_idx_d  = lock_idx_q;
    out_last_d  = out_last_q;
`endif
    if (load_c) begin
      out_valid_d = accept_c;
      if (accept_c) begin
        out_data_d = mux_y_c;
        out_sel_d  = grant_c;
`ifdef STREAM_ARB_PKT_LOCK_EN
        out_last_d = bus.in_last[grant_c];
        if (bus.in_last[grant_c]) begin
          ptr_d   = grant_c;
          state_d = IDLE;
        end else begin
          state_d    = LOCKED;
          lock_idx_d = grant_c;
        end
`else
        ptr_d      = grant_c;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= PTR_RST;
`ifdef STREAM_ARB_PKT_LOCK_EN
      state_q     <= IDLE;
      lock_idx_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_ARB_PKT_LOCK_EN
      state_q     <= state_d;
      lock_idx_q  <= lock_idx_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
`ifdef STREAM_ARB_PKT_LOCK_EN
  assign bus.out_last  = out_last_q;
`endif
endmodule

// File: doc/stream_arb_4_1.md
# stream_arb_4_1

Four-input round-robin stream arbiter that merges four 4-bit valid/ready channels into one registered output stream. It computes the 2-bit select for the existing `mux_4_1` data path, registers the selected word together with its source index, and feeds the downstream consumer. The block sits directly upstream of any single-channel consumer in the combinational-logic exercise chain.

## Interface
- Parameters: none; data width 4 and channel count 4 are fixed by `stream_arb_pkg`.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 4: bit i asserts when channel i offers a word.
- `in_ready` output 4: bit i is high when channel i's word is accepted this cycle; at most one bit is high.
- `d0`, `d1`, `d2`, `d3` input 4 each: channel data.
- `out_valid` output 1: registered word available.
- `out_ready` input 1: downstream accepts the word when high together with `out_valid`.
- `out_data` output 4: registered selected word.
- `out_sel` output 2: index of the channel that supplied `out_data`.
- `in_last` input 4 and `out_last` output 1: present only with `STREAM_ARB_PKT_LOCK_EN`.

## Operation
- `load = ~out_valid | out_ready`. This is the single-stage pipeline enable.
- Priority order is `ptr+1, ptr+2, ptr+3, ptr` (mod 4). `grant` is the first index in that order whose `in_valid` is high.
- `in_ready[grant] = load & |in_valid`. All other `in_ready` bits are 0. `in_ready` must not depend on `in_valid[i]` of the same channel except through the grant.
- On accept: `out_data <= d[grant]`, `out_sel <= grant`, `out_valid <= 1`, `ptr <= grant`.
- If `load` is high and no channel is valid: `out_valid <= 0`. Data and select hold their last values.
- If `out_valid & ~out_ready`: all output registers and `ptr` hold, and `in_ready = 0`.
- `ptr` wrap-around is natural 2-bit modulo arithmetic. No channel waits more than 3 accepts while it stays valid.
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `out_last=0`, `ptr=3` (channel 0 wins first), lock FSM in `IDLE`.
- Reset mid-operation discards the held output word. `in_ready` is 0 during the cycle `rst` is high.

## Timing
- Latency is 1 cycle from an `in_valid`/`in_ready` handshake to `out_valid`.
- Throughput is 1 word/cycle when `out_ready` is held high. An accept and an output drain in the same cycle is legal and required.
- Combinational paths: `in_valid`, `out_ready` -> `in_ready`. There is no combinational path from `d*` to outputs.
- `out_data`, `out_sel` and `out_valid` must stay stable while `out_valid & ~out_ready`.

## Configuration
- `STREAM_ARB_PKT_LOCK_EN` defined:
  - Adds the `in_last` and `out_last` ports and an FSM with states `IDLE` and `LOCKED`, plus a `lock_idx` register.
  - `IDLE`: arbitrate normally. Accepting a beat with `in_last=0` moves the FSM to `LOCKED` with `lock_idx=grant`.
  - `LOCKED`: grant only `lock_idx`, even if its `in_valid` is low; other channels stall.
  - Accepting a beat with `in_last=1` returns the FSM to `IDLE`.
  - `ptr` updates only on beats accepted with `in_last=1`. `out_last` is registered with the data.
- Not defined:
  - Every beat is arbitrated independently, with no FSM and no last ports.

## Structure
- `stream_arb_pkg` holds:
  - constants `DATA_W=4`, `N_CH=4`, `SEL_W=2`, `PTR_RST=2'd3`;
  - `typedef logic [DATA_W-1:0] data_t`;
  - `typedef logic [SEL_W-1:0] sel_t`;
  - `typedef enum logic {IDLE, LOCKED} lock_state_t`.
- One sub-module is natural: an instance of the existing `mux_4_1`, driven by `grant`, selects `d0..d3` before the output register.
- Grant logic and registers stay in the top module.

## Test plan
- Reset, then all four channels valid with `d0..d3=1,2,3,4` and `out_ready=1`:
  - `out_sel` sequence is 0,1,2,3,0…;
  - `out_data` sequence is 1,2,3,4,1…;
  - `out_valid` is continuous from cycle 1 after the first accept.
- Only channel 2 valid with `d2=4'hA`, and `out_ready=0` for 3 cycles:
  - `out_data=A` and `out_sel=2` are held;
  - `in_ready=0` while stalled;
  - exactly one beat of A is delivered after `out_ready` rises.
- Channels 1 and 3 valid, `ptr=1` after a channel-1 accept:
  - channel 3 wins next;
  - channel 1 wins the following cycle.
- Assert `rst` while `out_valid=1`:
  - next cycle `out_valid=0` and `out_data=0`;
  - the first grant afterwards goes to channel 0.
- No channel valid, `out_ready=1` after one word:
  - `out_valid` drops to 0 one cycle after the drain.
- With `STREAM_ARB_PKT_LOCK_EN`, channel 1 sends 3 beats (`in_last` 0,0,1) while channel 0 is continuously valid:
  - `out_sel=1` for all 3 beats;
  - the next grant goes to channel 0.
